// File: rtl/rxdata_pkg.sv
// Shared definitions for the hex-over-serial receive path: parser state
// encodings, ASCII constants and the hex-digit decoder.
package rxdata_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned SETUP_W    = 24;
    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] S_ZERO    = 3'd1;
    localparam logic [STATE_W-1:0] S_PREFIX  = 3'd2;
    localparam logic [STATE_W-1:0] S_DIGITS  = 3'd3;
    localparam logic [STATE_W-1:0] S_DISCARD = 3'd4;

    localparam logic [BYTE_W-1:0] ASCII_CR   = 8'h0d;
    localparam logic [BYTE_W-1:0] ASCII_LF   = 8'h0a;
    localparam logic [BYTE_W-1:0] ASCII_0    = 8'h30;
    localparam logic [BYTE_W-1:0] ASCII_X_LO = 8'h78;
    localparam logic [BYTE_W-1:0] ASCII_X_UP = 8'h58;

    // Returns {valid, nibble}; letters map via their low nibble (a/A = 1) plus 9.
    function automatic logic [4:0] hex_decode(input logic [BYTE_W-1:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
            r = {1'b1, 4'(c[3:0] + 4'd9)};
        return r;
    endfunction

endpackage

// File: rtl/rxdata_rxuart.sv
// rxuart: 8N1 byte receiver. Samples mid-bit after a half-baud start check
// and pulses o_wr for one cycle when a byte with a valid stop bit arrives.
module rxuart
    import rxdata_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [SETUP_W-1:0]  i_setup,
    input  logic                i_uart_rx,
    output logic                o_wr,
    output logic [BYTE_W-1:0]   o_data
);

    logic               rx_meta;
    logic               rx_sync;
    logic               busy;
    logic [SETUP_W-1:0] baud_cnt;
    logic [3:0]         bit_cnt;
    logic [BYTE_W-1:0]  sreg;

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Bit timing and shift: bit_cnt 0 = start, 1..8 = data, 9 = stop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
            o_wr     <= 1'b0;
            o_data   <= '0;
        end else begin
            o_wr <= 1'b0;
            if (!busy) begin
                if (!rx_sync) begin
                    busy     <= 1'b1;
                    baud_cnt <= i_setup >> 1;
                    bit_cnt  <= '0;
                end
            end else if (baud_cnt != '0) begin
                baud_cnt <= baud_cnt - SETUP_W'(1);
            end else begin
                baud_cnt <= i_setup - SETUP_W'(1);
                bit_cnt  <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd0) begin
                    if (rx_sync)
                        busy <= 1'b0;
                end else if (bit_cnt == 4'd9) begin
                    busy <= 1'b0;
                    if (rx_sync) begin
                        o_wr   <= 1'b1;
                        o_data <= sreg;
                    end
                end else begin
                    sreg <= {rx_sync, sreg[BYTE_W-1:1]};
                end
            end
        end
    end

endmodule

// File: rtl/rxdata_txuart.sv
// txuart: 8N1 byte transmitter used for the terminal echo.
// Only built when RXDATA_ECHO_EN is defined.
`ifdef RXDATA_ECHO_EN
module txuart
    import rxdata_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [SETUP_W-1:0]  i_setup,
    input  logic                i_wr,
    input  logic [BYTE_W-1:0]   i_data,
    output logic                o_busy,
    output logic                o_uart_tx
);

    logic               busy;
    logic [SETUP_W-1:0] baud_cnt;
    logic [3:0]         bit_cnt;
    logic [BYTE_W:0]    sreg;

    assign o_busy = busy;

    // Start bit, eight data bits LSB first, then a stop bit of ones.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy      <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            sreg      <= '1;
            o_uart_tx <= 1'b1;
        end else if (!busy) begin
            if (i_wr) begin
                busy      <= 1'b1;
                o_uart_tx <= 1'b0;
                sreg      <= {1'b1, i_data};
                baud_cnt  <= i_setup - SETUP_W'(1);
                bit_cnt   <= '0;
            end
        end else if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - SETUP_W'(1);
        end else begin
            baud_cnt <= i_setup - SETUP_W'(1);
            if (bit_cnt == 4'd9) begin
                busy <= 1'b0;
            end else begin
                o_uart_tx <= sreg[0];
                sreg      <= {1'b1, sreg[BYTE_W:1]};
                bit_cnt   <= bit_cnt + 4'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/rxdata.sv
// rxdata: parses ASCII hex lines ("0x%08x\r\n", prefix optional, 1-8 digits,
// CR or LF terminated) from the UART into a 32-bit word with a one-cycle strobe.
// Optional terminal echo on o_uart_tx when RXDATA_ECHO_EN is defined.
module rxdata
    import rxdata_pkg::*;
#(
    parameter int unsigned UART_SETUP = 868
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_uart_rx,
    output logic        o_stb,
    output logic [31:0] o_data,
    output logic        o_err,
    output logic        o_uart_tx
);

    localparam logic [SETUP_W-1:0] SETUP = SETUP_W'(UART_SETUP);

    logic              rx_stb;
    logic [BYTE_W-1:0] rx_data;

    logic [STATE_W-1:0] state, state_nxt;
    logic [DATA_W-1:0]  acc, acc_nxt, data_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               stb_nxt, err_nxt;
    logic               is_digit, is_term, is_x;
    logic [3:0]         nib;

    rxuart u_rx (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_setup   (SETUP),
        .i_uart_rx (i_uart_rx),
        .o_wr      (rx_stb),
        .o_data    (rx_data)
    );

    assign {is_digit, nib} = hex_decode(rx_data);
    assign is_term         = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
    assign is_x            = (rx_data == ASCII_X_LO) || (rx_data == ASCII_X_UP);

    // Parser state, accumulator and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= S_IDLE;
            acc    <= '0;
            cnt    <= '0;
            o_stb  <= 1'b0;
            o_err  <= 1'b0;
            o_data <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            o_stb  <= stb_nxt;
            o_err  <= err_nxt;
            o_data <= data_nxt;
        end
    end

    // Next-state logic: advances only on received bytes.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        stb_nxt   = 1'b0;
        err_nxt   = 1'b0;
        data_nxt  = o_data;
        if (rx_stb) begin
            case (state)
                S_IDLE: begin
                    if (is_digit) begin
                        acc_nxt   = DATA_W'(nib);
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = (rx_data == ASCII_0) ? S_ZERO : S_DIGITS;
                    end else if (!is_term) begin
                        state_nxt = S_DISCARD;
                        err_nxt   = 1'b1;
                    end
                end
                S_ZERO, S_PREFIX, S_DIGITS: begin
                    if (state == S_ZERO && is_x) begin
                        state_nxt = S_PREFIX;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                    end else if (is_digit && cnt < CNT_W'(MAX_DIGITS)) begin
                        state_nxt = S_DIGITS;
                        acc_nxt   = {acc[DATA_W-5:0], nib};
                        cnt_nxt   = cnt + CNT_W'(1);
                    end else if (is_term) begin
                        state_nxt = S_IDLE;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        if (state == S_PREFIX) begin
                            err_nxt  = 1'b1;
                        end else begin
                            stb_nxt  = 1'b1;
                            data_nxt = acc;
                        end
                    end else begin
                        state_nxt = S_DISCARD;
                        err_nxt   = 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (is_term) begin
                        state_nxt = S_IDLE;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef RXDATA_ECHO_EN
    logic              echo_stb;
    logic [BYTE_W-1:0] echo_data;
    logic              tx_busy;

    // Registered echo request; bytes arriving while the transmitter is busy are skipped.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            echo_stb  <= 1'b0;
            echo_data <= '0;
        end else begin
            echo_stb  <= rx_stb && !tx_busy;
            echo_data <= rx_data;
        end
    end

    txuart u_tx (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_setup   (SETUP),
        .i_wr      (echo_stb),
        .i_data    (echo_data),
        .o_busy    (tx_busy),
        .o_uart_tx (o_uart_tx)
    );
`else
    assign o_uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_rxdata.sv
// Testbench for rxdata: serial stimulus at a short baud, line-level reference
// model, event queues compared after each group of lines.
module tb_rxdata;

    localparam int unsigned BAUD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        stb;
    logic [31:0] data;
    logic        err;
    logic        tx;

    int checks = 0;
    int errors = 0;

    // Events: {is_error, value}; value is don't-care (0) for errors.
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    logic [7:0]  pend[$];
    logic [31:0] model_data = 32'h0;

    rxdata #(.UART_SETUP(BAUD)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_uart_rx (rx),
        .o_stb     (stb),
        .o_data    (data),
        .o_err     (err),
        .o_uart_tx (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Capture strobes/errors away from the active edge.
    always @(negedge clk) begin
        if (!rst && (stb || err)) begin
            chk("stb_err_exclusive", 33'(stb && err), 33'd0);
`ifndef RXDATA_ECHO_EN
            chk("uart_tx_idle", 33'(tx), 33'd1);
`endif
            if (err) got_q.push_back({1'b1, 32'h0});
            else     got_q.push_back({1'b0, data});
        end
    end

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    // Reference model: judges each completed line as a whole.
    function automatic void model_line();
        int start = 0;
        int n;
        bit ok = 1'b1;
        logic [31:0] v = 32'h0;
        if (pend.size() >= 2 && pend[0] == "0" && (pend[1] == "x" || pend[1] == "X"))
            start = 2;
        n = pend.size() - start;
        if (n < 1 || n > 8) ok = 1'b0;
        for (int i = start; i < pend.size(); i++) begin
            if (hexval(pend[i]) < 0) ok = 1'b0;
            else v = (v << 4) | 32'(hexval(pend[i]));
        end
        if (ok) begin
            exp_q.push_back({1'b0, v});
            model_data = v;
        end else begin
            exp_q.push_back({1'b1, 32'h0});
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'h0d || b == 8'h0a) begin
            if (pend.size() != 0) model_line();
            pend.delete();
        end else begin
            pend.push_back(b);
        end
    endfunction

    task automatic send_b(input logic [7:0] b);
        model_byte(b);
        @(posedge clk); rx = 1'b0;
        repeat (BAUD) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(posedge clk);
        end
        rx = 1'b1;
        repeat (BAUD) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_b(8'(s[i]));
    endtask

    task automatic settle(input string tag);
        repeat (2 * BAUD) @(posedge clk);
        chk({tag, "_count"}, 33'(got_q.size()), 33'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_event"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        chk({tag, "_data_held"}, 33'(data), 33'(model_data));
    endtask

    function automatic logic [7:0] hexc(input int n, input bit up);
        if (n < 10) return 8'(48 + n);
        return up ? 8'(55 + n) : 8'(87 + n);
    endfunction

    initial begin
        logic [7:0]  line[$];
        logic [31:0] val;
        int          nd;
        int          mode;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stb",  33'(stb),  33'd0);
        chk("reset_err",  33'(err),  33'd0);
        chk("reset_data", 33'(data), 33'd0);
        chk("reset_tx",   33'(tx),   33'd1);
        @(posedge clk); rst = 1'b0;
        repeat (BAUD) @(posedge clk);

        send_str("0x12345678"); send_b(8'h0d); send_b(8'h0a);
        settle("full_word");

        send_str("DEADbeef"); send_b(8'h0a); send_str("7"); send_b(8'h0d);
        settle("mixed_case");

        send_str("0"); send_b(8'h0d); send_str("0x"); send_b(8'h0d);
        settle("zero_and_bare_prefix");

        send_str("0x123456789"); send_b(8'h0d); send_str("0x1"); send_b(8'h0d);
        settle("nine_digits");

        send_str("0x12g4"); send_b(8'h0d); send_b(8'h0a); send_str("0xAB"); send_b(8'h0d);
        settle("bad_char");

        send_str("0x1234");
        @(posedge clk); rst = 1'b1;
        @(posedge clk); rst = 1'b0;
        pend.delete();
        model_data = 32'h0;
        @(negedge clk);
        chk("midline_reset_data", 33'(data), 33'd0);
        send_str("5"); send_b(8'h0d);
        settle("after_reset");

        for (int l = 0; l < 15; l++) begin
            line.delete();
            val  = $urandom;
            nd   = $urandom_range(1, 8);
            mode = $urandom_range(0, 9);
            if (mode == 1) nd = 9;
            if ($urandom_range(0, 1) == 1) begin
                line.push_back("0");
                line.push_back($urandom_range(0, 1) ? "x" : "X");
            end
            for (int d = nd - 1; d >= 0; d--)
                line.push_back(hexc(int'((val >> (4 * (d % 8))) & 32'hf), 1'($urandom_range(0, 1))));
            if (mode == 0) line[$urandom_range(0, line.size() - 1)] = "g";
            foreach (line[i]) send_b(line[i]);
            case ($urandom_range(0, 2))
                0:       send_b(8'h0d);
                1:       send_b(8'h0a);
                default: begin send_b(8'h0d); send_b(8'h0a); end
            endcase
            settle("random_line");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rxdata.md
Name: rxdata

Overview:
- Receive side of the hex-over-serial debug link: deserializes UART bytes and parses an ASCII hex line of the form "0x%08x\r\n" into a 32-bit word.
- Inputs are tolerant: optional prefix, 1–8 digits, either case, CR or LF terminator.
- Sits between the board's UART RX pin and any register or command consumer. Emits a one-cycle strobe per parsed word.

Parameters:
- UART_SETUP, 868, clocks per baud. Passed to the byte receiver as a 24-bit value.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous reset, active high
- i_uart_rx  input  1  serial line in; idle high
- o_stb  output  1  one-cycle pulse: o_data holds a newly parsed word
- o_data  output  32  last parsed value, right-aligned, zero-extended
- o_err  output  1  one-cycle pulse on a malformed line
- o_uart_tx  output  1  echo line; see Optional Feature

Behaviour:
- Interface: one clock i_clk. i_reset is synchronous and active-high.
- Reset values: o_stb=0, o_err=0, o_data=0, o_uart_tx=1, state=IDLE, accumulator=0, digit count=0. The byte receiver is also reset.
- Byte source: rx_stb and rx_data[7:0] from the byte receiver. Parser state advances only on cycles where rx_stb=1.
- Hex digits: '0'-'9', 'a'-'f', 'A'-'F'. Terminators: CR (0x0D) and LF (0x0A).
- Per accepted digit: acc <= {acc[27:0], nibble}; cnt <= cnt+1. cnt is 4 bits.
- IDLE:
  - '0' -> ZERO, acc=0, cnt=1.
  - other digit -> DIGITS, acc=nibble, cnt=1.
  - terminator -> stay IDLE. Empty line; no strobe, no error. This makes CRLF pairs harmless.
  - anything else -> DISCARD, o_err.
- ZERO:
  - 'x' or 'X' -> PREFIX, acc=0, cnt=0.
  - digit -> DIGITS (accumulate).
  - terminator -> emit value 0.
  - other -> DISCARD, o_err.
- PREFIX:
  - digit -> DIGITS.
  - terminator -> IDLE with o_err. "0x" with no digits is an error.
  - other -> DISCARD, o_err.
- DIGITS:
  - digit with cnt<8 -> accumulate.
  - digit with cnt==8 (9th digit) -> DISCARD, o_err.
  - terminator -> emit.
  - other -> DISCARD, o_err.
- DISCARD: ignore all bytes until a terminator, then IDLE. No further o_err pulses for the same line.
- Emit:
  - Registered on the clock edge sampling the terminator's rx_stb, so o_stb is high the following cycle.
  - o_data is updated on that same edge.
  - Next state IDLE; acc and cnt cleared.
- o_data holds its value between strobes and is unchanged by errors.
- o_err fires the cycle after the offending byte's rx_stb.
- o_stb and o_err are never high together.
- Reset mid-line: partial acc discarded, state IDLE, no strobe.
- A byte arriving on the same cycle as i_reset is lost.
- Back-to-back lines need no gap. The parser never back-pressures; a byte takes at least 10 baud periods.

Optional Feature:
- Macro: RXDATA_ECHO_EN.
- Defined:
  - Every received byte is forwarded to a transmitter instance (same UART_SETUP) driving o_uart_tx, giving a terminal echo.
  - If the transmitter is busy when rx_stb fires, that byte is dropped from the echo only. Parsing is unaffected.
  - The echo strobe is registered: the transmit request is issued the cycle after rx_stb.
- Undefined: o_uart_tx tied to 1; no transmitter is instantiated.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE, ZERO, PREFIX, DIGITS, DISCARD;
  - ASCII constants CR, LF, '0', 'x', 'X';
  - a hex-digit decode function returning {valid, nibble[3:0]}.
- The transmit side reuses the same ASCII constants.
- Natural sub-module: rxuart, the existing 8N1 byte receiver (i_clk, i_uart_rx -> rx_stb, rx_data).
- rxdata holds only the parser and output registers.

Test Plan:
- Send "0x12345678\r\n" -> exactly one o_stb with o_data=32'h12345678, one cycle after the CR byte. LF produces nothing; o_err never asserts.
- Send "DEADbeef\n" then "7\r" -> o_data=32'hdeadbeef, then o_data=32'h00000007. Two strobes total.
- Send "0\r" and "0x\r" -> first gives o_stb with o_data=0. Second gives o_err only, and o_data stays 0.
- Send "0x123456789\r" then "0x1\r" -> o_err after the 9th digit, no strobe for that line. The next line strobes o_data=1.
- Send "0x12g4\r\n0xAB\r" -> one o_err at 'g', then a single strobe o_data=32'h000000ab.
- Assert i_reset after receiving "0x1234"; after release send "5\r" -> o_data=32'h00000005 (not 0x12345). With RXDATA_ECHO_EN defined, o_uart_tx reproduces each received byte at the same baud.
